traffic_cmd_parser: RTL

- Upstream command front-end for the traffic-light controller.
- Accepts a byte stream over a valid/ready handshake, frames it into 1- or 3-byte command packets, and validates them.
- Emits the single-cycle cmd_type/cmd_valid/cmd_data command interface the controller consumes.
- Malformed packets and inter-byte timeouts are dropped and counted.

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/traffic_cmd_parser.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic-light command path.
package traffic_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CMD_TYPE_W = 3;
  localparam int unsigned CMD_DATA_W = 16;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  typedef enum logic [CMD_TYPE_W-1:0] {
    CMD_RED        = 3'd0,
    CMD_OFF        = 3'd1,
    CMD_NOTRANS    = 3'd2,
    CMD_SET_GREEN  = 3'd3,
    CMD_SET_RED    = 3'd4,
    CMD_SET_YELLOW = 3'd5
  } cmd_type_e;

  typedef struct packed {
    logic [3:0]            sync;
    logic                  has_data;
    logic [CMD_TYPE_W-1:0] ctype;
  } hdr_t;

  function automatic logic cmd_has_data(input logic [CMD_TYPE_W-1:0] t);
    return (t == CMD_SET_GREEN) || (t == CMD_SET_RED) || (t == CMD_SET_YELLOW);
  endfunction

  function automatic logic cmd_legal(input logic [CMD_TYPE_W-1:0] t);
    return t <= CMD_SET_YELLOW;
  endfunction

endpackage

// File: rtl/traffic_cmd_parser.sv
// Frames a valid/ready byte stream into 1- or 3-byte command packets and
// issues one-cycle command strobes; malformed or timed-out packets are counted.
module traffic_cmd_parser
  import traffic_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 200,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic [BYTE_W-1:0]     byte_data_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic [CMD_TYPE_W-1:0] cmd_type_o,
  output logic                  cmd_valid_o,
  output logic [CMD_DATA_W-1:0] cmd_data_o,
  output logic                  err_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DATA_HI = 2'd1,
    S_DATA_LO = 2'd2,
    S_EMIT    = 2'd3
  } state_e;

  state_e                r_state;
  state_e                w_next;
  logic [GAP_W-1:0]      r_gap;
  logic [GAP_W-1:0]      w_gap_next;
  logic                  r_ready;
  logic                  r_err;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic                  r_cmd_valid;
  logic [CMD_TYPE_W-1:0] r_cmd_type;
  logic [CMD_DATA_W-1:0] r_cmd_data;
  logic [CMD_TYPE_W-1:0] r_pkt_type;
  logic [CMD_DATA_W-1:0] r_pkt_data;

  logic                  w_accept;
  logic                  w_hdr_ok;
  logic                  w_err;
  logic                  w_emit;
  logic                  w_latch_hdr;
  logic                  w_latch_hi;
  logic                  w_latch_lo;
  hdr_t                  w_hdr;

  assign w_hdr    = hdr_t'(byte_data_i);
  assign w_accept = byte_valid_i && r_ready;
  assign w_hdr_ok = (w_hdr.sync == SYNC_NIBBLE) && cmd_legal(w_hdr.ctype) &&
                    (w_hdr.has_data == cmd_has_data(w_hdr.ctype));

  // Next-state, gap counter and strobe decode
  always_comb begin
    w_next      = r_state;
    w_gap_next  = r_gap;
    w_err       = 1'b0;
    w_emit      = 1'b0;
    w_latch_hdr = 1'b0;
    w_latch_hi  = 1'b0;
    w_latch_lo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gap_next = '0;
        if (w_accept) begin
          if (!w_hdr_ok) begin
            w_err = 1'b1;
          end else begin
            w_latch_hdr = 1'b1;
            w_next      = w_hdr.has_data ? S_DATA_HI : S_EMIT;
          end
        end
      end
      S_DATA_HI, S_DATA_LO: begin
        // An accepted byte takes priority over an expiring gap
        if (w_accept) begin
          w_gap_next = '0;
          if (r_state == S_DATA_HI) begin
            w_latch_hi = 1'b1;
            w_next     = S_DATA_LO;
          end else begin
            w_latch_lo = 1'b1;
            w_next     = S_EMIT;
          end
        end else if (r_gap == GAP_W'(TIMEOUT_TICKS - 1)) begin
          w_gap_next = '0;
          w_err      = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_gap_next = r_gap + GAP_W'(1);
        end
      end
      S_EMIT: begin
        w_emit = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
    end else begin
      r_state <= w_next;
      r_gap   <= w_gap_next;
    end
  end

  // Packet assembly, command outputs and error accounting
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= '0;
      r_cmd_data  <= '0;
      r_pkt_type  <= '0;
      r_pkt_data  <= '0;
    end else begin
      r_ready     <= (w_next != S_EMIT);
      r_err       <= w_err;
      r_cmd_valid <= w_emit;
      if (w_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
      end
      if (w_latch_hdr) begin
        r_pkt_type <= w_hdr.ctype;
        r_pkt_data <= '0;
      end
      if (w_latch_hi) begin
        r_pkt_data[15:8] <= byte_data_i;
      end
      if (w_latch_lo) begin
        r_pkt_data[7:0] <= byte_data_i;
      end
      if (w_emit) begin
        r_cmd_type <= r_pkt_type;
        r_cmd_data <= r_pkt_data;
      end
    end
  end

  assign byte_ready_o = r_ready;
  assign err_o        = r_err;
  assign err_cnt_o    = r_err_cnt;
  assign cmd_valid_o  = r_cmd_valid;
  assign cmd_type_o   = r_cmd_type;
  assign cmd_data_o   = r_cmd_data;

endmodule
